// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline hazard controller.
//   REG_W        register index width
//   fwd_sel_t    EX operand source select (FWD_RF / FWD_WB / FWD_MEM)
//   state_t      data-memory handshake FSM states
//   pipe_ctl_t   bundle of all pipeline-register enable/clear strobes
package core_pkg;
  localparam int REG_W = 5;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic en_pc;
    logic en_fd;
    logic clr_fd;
    logic en_de;
    logic clr_de;
    logic en_em;
    logic clr_em;
    logic en_mw;
    logic clr_mw;
  } pipe_ctl_t;

  // Normal flow: everything advances, nothing cleared.
  localparam pipe_ctl_t CTL_RUN = '{en_pc: 1'b1, en_fd: 1'b1, clr_fd: 1'b0,
                                    en_de: 1'b1, clr_de: 1'b0, en_em: 1'b1,
                                    clr_em: 1'b0, en_mw: 1'b1, clr_mw: 1'b0};
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational forwarding select for one EX source operand.
//   rs_e                 source register index in EX
//   rd_m, reg_write_m    MEM-stage destination / write type (nonzero = writes)
//   rd_w, reg_write_w    WB-stage destination / write type (nonzero = writes)
//   fwd                  FWD_MEM, FWD_WB or FWD_RF
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [2:0]       reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic [2:0]       reg_write_w,
  output fwd_sel_t         fwd
);
  // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
  always_comb begin
    fwd = FWD_RF;
    if ((reg_write_m != 3'd0) && (rd_m != '0) && (rd_m == rs_e))
      fwd = FWD_MEM;
    else if ((reg_write_w != 3'd0) && (rd_w != '0) && (rd_w == rs_e))
      fwd = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
//   Inputs : stage register indices, load/write flags, branch/jump resolution,
//            dmem_ready from the data bus.
//   Outputs: en_pc, en_*/clr_* per pipeline register, fwd1_e/fwd2_e operand
//            selects, dmem_valid bus request, bus_err timeout pulse,
//            stall_cnt (cycles with en_pc low, wrapping).
// Priority of control: reset > memory stall > EX flush > load-use > jal in ID.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_to_reg_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [2:0]       reg_write_m,
  input  logic             mem_to_reg_m,
  input  logic [3:0]       mem_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic [2:0]       reg_write_w,
  input  logic             branch_taken_e,
  input  logic             jalr_e,
  input  logic             jal_d,
  input  logic             dmem_ready,
  output logic             en_pc,
  output logic             en_fd,
  output logic             clr_fd,
  output logic             en_de,
  output logic             clr_de,
  output logic             en_em,
  output logic             clr_em,
  output logic             en_mw,
  output logic             clr_mw,
  output logic [1:0]       fwd1_e,
  output logic [1:0]       fwd2_e,
  output logic             dmem_valid,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int NUM_OPS = 2;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  pipe_ctl_t         ctl;

  logic mem_req_m, timeout, mem_stall, load_use, ex_flush;

  assign mem_req_m = mem_to_reg_m | (mem_write_m != 4'd0);
  // Last allowed wait cycle with no response: abort and let MEM/WB capture.
  assign timeout   = (state == MEM_WAIT) && (wait_cnt == WAIT_W'(MAX_WAIT - 1)) && !dmem_ready;
  assign mem_stall = ((state == RUN) && mem_req_m && !dmem_ready) ||
                     ((state == MEM_WAIT) && !dmem_ready && !timeout);
  assign load_use  = mem_to_reg_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign ex_flush  = branch_taken_e | jalr_e;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      bus_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      bus_err  <= timeout;
      if (!ctl.en_pc) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_req_m && !dmem_ready) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || timeout) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    ctl        = CTL_RUN;
    dmem_valid = 1'b0;
    if (rst) begin
      // Drain: every register enabled and cleared.
      ctl = '{en_pc: 1'b1, en_fd: 1'b1, clr_fd: 1'b1, en_de: 1'b1, clr_de: 1'b1,
              en_em: 1'b1, clr_em: 1'b1, en_mw: 1'b1, clr_mw: 1'b1};
    end else begin
      dmem_valid = (state == MEM_WAIT) || mem_req_m;
      if (mem_stall) begin
        // Freeze front of pipe, feed a bubble into WB.
        ctl.en_pc  = 1'b0;
        ctl.en_fd  = 1'b0;
        ctl.en_de  = 1'b0;
        ctl.en_em  = 1'b0;
        ctl.clr_mw = 1'b1;
      end else if (ex_flush) begin
        ctl.clr_fd = 1'b1;
        ctl.clr_de = 1'b1;
      end else if (load_use) begin
        // IF/ID is held, so a jal in ID must not be cleared here.
        ctl.en_pc  = 1'b0;
        ctl.en_fd  = 1'b0;
        ctl.clr_de = 1'b1;
      end else if (jal_d) begin
        ctl.clr_fd = 1'b1;
      end
    end
  end

  assign en_pc  = ctl.en_pc;
  assign en_fd  = ctl.en_fd;
  assign clr_fd = ctl.clr_fd;
  assign en_de  = ctl.en_de;
  assign clr_de = ctl.clr_de;
  assign en_em  = ctl.en_em;
  assign clr_em = ctl.clr_em;
  assign en_mw  = ctl.en_mw;
  assign clr_mw = ctl.clr_mw;

  // ---------------- forwarding ----------------
  logic [NUM_OPS-1:0][REG_W-1:0] rs_e;
  fwd_sel_t [NUM_OPS-1:0]        fwd;

  assign rs_e = {rs2_e, rs1_e};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    fwd_unit u_fwd (
      .rs_e        (rs_e[i]),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .fwd         (fwd[i])
    );
  end

  assign fwd1_e = rst ? FWD_RF : fwd[0];
  assign fwd2_e = rst ? FWD_RF : fwd[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT = 4).
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       mem_to_reg_e, mem_to_reg_m, branch_taken_e, jalr_e, jal_d, dmem_ready;
  logic [2:0] reg_write_m, reg_write_w;
  logic [3:0] mem_write_m;
  logic       en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw;
  logic [1:0] fwd1_e, fwd2_e;
  logic       dmem_valid, bus_err;
  logic [31:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Packed as {en_pc,en_fd,clr_fd,en_de,clr_de,en_em,clr_em,en_mw,clr_mw}
  localparam logic [8:0] C_RST   = 9'b111111111;
  localparam logic [8:0] C_RUN   = 9'b110101010;
  localparam logic [8:0] C_LU    = 9'b000111010;
  localparam logic [8:0] C_MEM   = 9'b000000011;
  localparam logic [8:0] C_FLUSH = 9'b111111010;
  localparam logic [8:0] C_JAL   = 9'b111101010;

  logic [8:0] ctl;
  assign ctl = {en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw};

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .mem_to_reg_e(mem_to_reg_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .branch_taken_e(branch_taken_e), .jalr_e(jalr_e),
    .jal_d(jal_d), .dmem_ready(dmem_ready),
    .en_pc(en_pc), .en_fd(en_fd), .clr_fd(clr_fd), .en_de(en_de), .clr_de(clr_de),
    .en_em(en_em), .clr_em(clr_em), .en_mw(en_mw), .clr_mw(clr_mw),
    .fwd1_e(fwd1_e), .fwd2_e(fwd2_e), .dmem_valid(dmem_valid), .bus_err(bus_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; branch_taken_e = 0; jalr_e = 0; jal_d = 0;
    dmem_ready = 0; reg_write_m = '0; reg_write_w = '0; mem_write_m = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Activity during reset must be masked.
    mem_to_reg_m = 1; rd_m = 5'd7; reg_write_m = 3'd1; rs1_e = 5'd7;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_dvalid", 32'(dmem_valid), 32'd0);
    chk("rst_fwd1", 32'(fwd1_e), 32'd0);
    tick(); tick(); tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("post_rst_ctl", 32'(ctl), 32'(C_RUN));
    chk("post_rst_cnt", stall_cnt, 32'd0);
    chk("post_rst_berr", 32'(bus_err), 32'd0);
    chk("post_rst_dvalid", 32'(dmem_valid), 32'd0);

    // ---- load-use ----
    mem_to_reg_e = 1; rd_e = 5'd5; rs2_d = 5'd5; #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick(); clear_inputs(); #1;
    chk("lu_cnt", stall_cnt, 32'd1);
    chk("lu_release", 32'(ctl), 32'(C_RUN));
    mem_to_reg_e = 1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0; #1;
    chk("lu_x0", 32'(ctl), 32'(C_RUN));
    // jal alone, then branch flush overriding a load-use
    clear_inputs(); jal_d = 1; #1;
    chk("jal_ctl", 32'(ctl), 32'(C_JAL));
    mem_to_reg_e = 1; rd_e = 5'd3; rs1_d = 5'd3; branch_taken_e = 1; #1;
    chk("flush_over_lu", 32'(ctl), 32'(C_FLUSH));
    clear_inputs(); jalr_e = 1; #1;
    chk("jalr_flush", 32'(ctl), 32'(C_FLUSH));
    tick(); clear_inputs(); #1;
    chk("lu_x0_cnt", stall_cnt, 32'd1);

    // ---- forwarding ----
    rd_m = 5'd7; rd_w = 5'd7; reg_write_m = 3'd1; reg_write_w = 3'd2;
    rs1_e = 5'd7; rs2_e = 5'd7; #1;
    chk("fwd1_mem", 32'(fwd1_e), 32'd2);
    chk("fwd2_mem", 32'(fwd2_e), 32'd2);
    reg_write_m = 3'd0; #1;
    chk("fwd1_wb", 32'(fwd1_e), 32'd1);
    rs1_e = 5'd0; #1;
    chk("fwd1_x0", 32'(fwd1_e), 32'd0);
    chk("fwd2_wb", 32'(fwd2_e), 32'd1);
    rd_w = 5'd8; #1;
    chk("fwd2_none", 32'(fwd2_e), 32'd0);
    clear_inputs(); #1;

    // ---- memory wait: 3 not-ready cycles then ready ----
    mem_to_reg_m = 1; dmem_ready = 0; #1;
    chk("mw1_valid", 32'(dmem_valid), 32'd1);
    chk("mw1_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("mw2_valid", 32'(dmem_valid), 32'd1);
    chk("mw2_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("mw3_ctl", 32'(ctl), 32'(C_MEM));
    tick(); dmem_ready = 1; #1;
    chk("mw4_valid", 32'(dmem_valid), 32'd1);
    chk("mw4_ctl", 32'(ctl), 32'(C_RUN));
    tick(); clear_inputs(); #1;
    chk("mw5_valid", 32'(dmem_valid), 32'd0);
    chk("mw5_ctl", 32'(ctl), 32'(C_RUN));
    chk("mw_cnt", stall_cnt, 32'd4);
    chk("mw_berr", 32'(bus_err), 32'd0);

    // ---- timeout (store that never completes) ----
    mem_write_m = 4'hF; #1;
    chk("to1_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("to2_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("to3_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("to4_valid", 32'(dmem_valid), 32'd1);
    chk("to4_ctl", 32'(ctl), 32'(C_RUN));
    chk("to4_berr", 32'(bus_err), 32'd0);
    tick(); clear_inputs(); #1;
    chk("to_berr", 32'(bus_err), 32'd1);
    chk("to_resume", 32'(ctl), 32'(C_RUN));
    chk("to_dvalid", 32'(dmem_valid), 32'd0);
    chk("to_cnt", stall_cnt, 32'd7);
    tick();
    chk("to_berr_end", 32'(bus_err), 32'd0);

    // ---- memory stall + branch ----
    mem_to_reg_m = 1; branch_taken_e = 1; #1;
    chk("sb1_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("sb2_ctl", 32'(ctl), 32'(C_MEM));
    tick(); dmem_ready = 1; #1;
    chk("sb3_ctl", 32'(ctl), 32'(C_FLUSH));
    tick(); clear_inputs(); #1;
    chk("sb_ctl", 32'(ctl), 32'(C_RUN));
    chk("sb_cnt", stall_cnt, 32'd9);

    // ---- reset in MEM_WAIT ----
    mem_to_reg_m = 1; #1;
    tick(); tick();
    rst = 1; #1;
    chk("rw_dvalid", 32'(dmem_valid), 32'd0);
    chk("rw_ctl", 32'(ctl), 32'(C_RST));
    tick(); clear_inputs(); #1;
    chk("rw_berr", 32'(bus_err), 32'd0);
    chk("rw_cnt", stall_cnt, 32'd0);
    rst = 0; #1;
    chk("rw_run", 32'(ctl), 32'(C_RUN));
    tick();
    chk("rw_berr2", 32'(bus_err), 32'd0);
    chk("rw_dvalid2", 32'(dmem_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage core's pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives every en/clear pair and the PC enable.
- Resolves load-use stalls, branch/jump flushes and EX operand forwarding.
- Runs a handshake FSM that holds the pipeline while the data-memory bus completes a multi-cycle access, with a timeout.
- Sits beside the datapath; all pipeline registers take their en/clear from this block.

Parameters:
MAX_WAIT, 16, max cycles in MEM_WAIT before forced abort (>=2)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
rs1_d  in  5  rs1 index in ID
rs2_d  in  5  rs2 index in ID
rs1_e  in  5  rs1 index in EX
rs2_e  in  5  rs2 index in EX
rd_e  in  5  destination in EX
mem_to_reg_e  in  1  EX instruction is a load
rd_m  in  5  destination in MEM
reg_write_m  in  3  MEM write-type; nonzero = writes rd
mem_to_reg_m  in  1  MEM instruction is a load
mem_write_m  in  4  MEM byte-store mask
rd_w  in  5  destination in WB
reg_write_w  in  3  WB write-type; nonzero = writes rd
branch_taken_e  in  1  taken branch resolved in EX
jalr_e  in  1  jalr in EX
jal_d  in  1  jal decoded in ID
dmem_ready  in  1  bus completes access this cycle
en_pc  out  1  PC update enable
en_fd, clr_fd  out  1,1  IF/ID enable/clear
en_de, clr_de  out  1,1  ID/EX enable/clear
en_em, clr_em  out  1,1  EX/MEM enable/clear
en_mw, clr_mw  out  1,1  MEM/WB enable/clear
fwd1_e, fwd2_e  out  2,2  EX operand select: 00 regfile, 01 WB, 10 MEM
dmem_valid  out  1  bus request valid
bus_err  out  1  one-cycle pulse on timeout abort
stall_cnt  out  CNT_W  total stalled cycles, wraps

Behaviour:
- mem_req_m = mem_to_reg_m | (mem_write_m != 0).
- Registered: state, wait_cnt, stall_cnt, bus_err.
- Combinational from current state and inputs: en/clr, fwd, dmem_valid.
- FSM states: RUN, MEM_WAIT.
  - RUN, mem_req_m & !dmem_ready: go to MEM_WAIT, wait_cnt <= 1.
  - RUN, mem_req_m & dmem_ready: stay in RUN, no stall.
  - MEM_WAIT, dmem_ready: go to RUN.
  - MEM_WAIT, wait_cnt == MAX_WAIT-1 & !dmem_ready: go to RUN, bus_err <= 1 for exactly one cycle; MEM/WB captures the instruction anyway (load data undefined).
  - MEM_WAIT otherwise: wait_cnt++.
- dmem_valid = mem_req_m in RUN; 1 in MEM_WAIT; 0 during rst.
- Memory stall, active when (RUN & mem_req_m & !dmem_ready) | (MEM_WAIT & !dmem_ready & !timeout):
  - en_pc = en_fd = en_de = en_em = 0.
  - en_mw = 1, clr_mw = 1 (bubble into WB).
  - All other clears 0.
  - Highest priority; masks load-use and flush.
- Load-use stall, when no memory stall and mem_to_reg_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d):
  - en_pc = 0, en_fd = 0, en_de = 1, clr_de = 1.
- EX flush, when branch_taken_e | jalr_e (and no memory stall):
  - clr_fd = 1, clr_de = 1, en_pc = 1.
  - Overrides load-use and jal_d.
- jal_d alone: clr_fd = 1.
- Default: all en = 1, all clr = 0.
- Forwarding, per operand (shown for fwd1_e):
  - 10 if reg_write_m != 0 & rd_m != 0 & rd_m == rs1_e.
  - Else 01 if reg_write_w != 0 & rd_w != 0 & rd_w == rs1_e.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded.
- stall_cnt increments each cycle en_pc == 0; wraps at 2^CNT_W.
- Reset:
  - While rst: state = RUN, wait_cnt = 0, stall_cnt = 0, bus_err = 0, dmem_valid = 0, all en = 1, all clr = 1 (pipeline drained).
  - fwd outputs = 00 during rst.
  - rst asserted in MEM_WAIT abandons the access with no bus_err.

Decomposition:
- Shared package core_pkg:
  - fwd select constants FWD_RF/FWD_WB/FWD_MEM.
  - state enum {RUN, MEM_WAIT}.
  - REG_W = 5.
- One natural sub-module: fwd_unit (pure combinational forwarding compare), instantiated once per operand.

Test Plan:
1. Reset held 3 cycles, then released: during rst all clr = 1, dmem_valid = 0; after release en = 1, clr = 0, stall_cnt = 0.
2. Load-use: mem_to_reg_e = 1, rd_e = 5, rs2_d = 5 -> en_pc = 0, en_fd = 0, clr_de = 1 for 1 cycle; stall_cnt = 1. Repeat with rd_e = 0 -> no stall.
3. Forwarding: rd_m = rd_w = 7, rs1_e = 7, both writes -> fwd1_e = 10; then reg_write_m = 0 -> fwd1_e = 01; rs1_e = 0 -> 00.
4. Memory wait: mem_to_reg_m = 1, dmem_ready low 3 cycles then high -> dmem_valid high 4 cycles; en_em = 0 and clr_mw = 1 for 3 cycles; RUN on 5th; stall_cnt += 3.
5. Timeout, MAX_WAIT = 4, dmem_ready never high -> bus_err pulses 1 cycle after 4 valid cycles; pipeline resumes.
6. Simultaneous events:
   - Memory stall + branch_taken_e -> no flush while stalled; flush appears on the release cycle.
   - rst mid MEM_WAIT -> dmem_valid = 0 that cycle, bus_err stays 0.
